dma_tlp_gen: RTL and testbench
==============================

// Module: dma_tlp_gen
// PURPOSE
//  Converts DMA transfer requests (32-bit address, DW count, read/write) into PCIe 3DW MWr/MRd TLPs.
//  Emits the TLPs as 64-bit words into the TX packet FIFO write port. Runs in the wb_clk domain.
//  Splits each request at MAX_PAYLOAD_DW (writes), MAX_RDREQ_DW (reads) and every 4KB boundary.
//  Pulls write payload from a show-ahead 64-bit data FIFO.
// PARAMETERS
//  MAX_PAYLOAD_DW  32   max DWs per MWr TLP; even, power of 2, <=512
//  MAX_RDREQ_DW    128  max DWs per MRd TLP; power of 2, <=512
// PORTS
//  wb_clk       in   1   clock (only clock)
//  rstn         in   1   asynchronous active-low reset
//  req_valid    in   1   transfer request valid
//  req_ready    out  1   request accepted when req_valid&&req_ready
//  req_write    in   1   1=MWr, 0=MRd
//  req_addr     in   32  byte address; [1:0] ignored; writes require [2:0]=0
//  req_len_dw   in   16  total DWs; writes: bit0 forced 0
//  req_tag      in   8   tag of first MRd TLP; +1 per subsequent MRd TLP (mod 256)
//  requester_id in   16  placed in DW1[31:16]
//  req_done     out  1   1-cycle pulse when the last TLP of the request has been emitted
//  pl_data      in   64  payload word, show-ahead; [63:32] = lower-address DW
//  pl_empty     in   1   payload FIFO empty
//  pl_rd        out  1   pop pl_data (combinational)
//  fifo_full    in   1   TX FIFO almost-full
//  tx_dv        out  1   word valid (TX FIFO write enable)
//  tx_st_in     out  1   first word of TLP
//  tx_end_in    out  1   last word of TLP
//  tx_dwen_in   out  1   last word carries only [63:32]
//  tx_data_in   out  64  TLP word; [63:32] = earlier DW
// BEHAVIOUR
//  - Reset: all outputs 0 except req_ready, which is 1 once in IDLE. Remaining count, address and hold register cleared.
//    Reset mid-TLP truncates the TLP. The TX FIFO shares rstn.
//  - States: IDLE -> CALC -> HDR0 -> HDR1 -> [DATA] -> (CALC | DONE) -> IDLE.
//  - IDLE: req_ready=1. On accept, latch all req_* fields and go to CALC.
//    req_len_dw==0: go to DONE, emit no TLP.
//  - CALC: L = min(rem, MAX, (4096-addr[11:0])>>2). Length field = L[9:0]; L=512 encodes as 0.
//  - HDR0: wait while fifo_full. Then emit W0 = {DW0,DW1}, tx_st=1.
//      DW0 = {8'h40 (MWr) | 8'h00 (MRd), 14'd0, L[9:0]}
//      DW1 = {requester_id, tag (0 for MWr), lastBE, firstBE}
//      firstBE = 4'hF. lastBE = 4'hF, or 4'h0 when L==1.
//  - fifo_full is sampled only in HDR0; once started, a TLP streams to completion.
//  - HDR1, MRd: emit {DW2, 32'h0} with tx_end=1, tx_dwen=1. DW2 = {addr[31:2],2'b00}.
//  - HDR1, MWr: wait while pl_empty. Then emit {DW2, pl_data[63:32]}, pl_rd=1, hold <= pl_data[31:0].
//  - DATA (MWr): L/2 more words.
//      Non-last: stall while pl_empty (tx_dv=0). Otherwise emit {hold, pl_data[63:32]}, pl_rd=1, reload hold.
//      Last: emit {hold, 32'h0} with tx_end=1, tx_dwen=1, no pop.
//  - Word counts: MWr TLP = 2+L/2 words, L/2 pops. MRd TLP = 2 words.
//  - tx_dv=0 on every stall or idle cycle. Control bits are meaningful only when tx_dv=1.
//  - After each TLP: addr += L*4, rem -= L, tag += 1 for MRd. rem>0 -> CALC, else DONE.
//  - DONE: req_done=1 for one cycle, then IDLE.
//  - Minimum gap: one CALC cycle between TLPs. New request accepted the cycle after req_done.
//  - All tx_* outputs and req_done are registered. pl_rd is combinational from state and pl_empty.
// TESTING
//  T1 MWr addr=0x1000 len=8, pl words 1..4:
//     -> 6 words: W0 = DW0 0x40000008; W1 = {0x1000, P0}; last word dwen=1, end=1; 4 pops; req_done.
//  T2 MRd addr=0x2000 len=300 tag=5:
//     -> 3 TLPs, len 128/128/44, addr 0x2000/0x2200/0x2400, tags 5/6/7, each 2 words.
//  T3 MWr addr=0x0FF8 len=4:
//     -> TLP len=2 at 0xFF8, then TLP len=2 at 0x1000 (4KB split).
//  T4 MRd len=1 -> lastBE=0, firstBE=F. req_len_dw=0 -> req_done, no tx_dv.
//  T5 fifo_full high in HDR0 holds off tx_st for 10 cycles. pl_empty toggled mid-DATA
//     -> stall with tx_dv=0, no data loss or duplication.
//  T6 rstn asserted mid-DATA -> all outputs 0 immediately; next request after release emits a clean TLP.

Source files
------------

// File: rtl/dma_tlp_gen_if.sv
// Request, payload-FIFO and TX-FIFO signals of the DMA TLP generator.
// The master side issues requests and owns both FIFOs; the slave side is the generator.
interface dma_tlp_gen_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [31:0] req_addr;
  logic [15:0] req_len_dw;
  logic [7:0]  req_tag;
  logic [15:0] requester_id;
  logic        req_done;
  logic [63:0] pl_data;
  logic        pl_empty;
  logic        pl_rd;
  logic        fifo_full;
  logic        tx_dv;
  logic        tx_st_in;
  logic        tx_end_in;
  logic        tx_dwen_in;
  logic [63:0] tx_data_in;

  modport master (
    output req_valid, req_write, req_addr, req_len_dw, req_tag, requester_id,
    output pl_data, pl_empty, fifo_full,
    input  req_ready, req_done, pl_rd,
    input  tx_dv, tx_st_in, tx_end_in, tx_dwen_in, tx_data_in
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_len_dw, req_tag, requester_id,
    input  pl_data, pl_empty, fifo_full,
    output req_ready, req_done, pl_rd,
    output tx_dv, tx_st_in, tx_end_in, tx_dwen_in, tx_data_in
  );
endinterface

// File: rtl/dma_tlp_gen.sv
// Turns DMA requests into 3DW MWr/MRd TLPs written as 64-bit words into the TX FIFO,
// splitting at the max payload / read-request size and at every 4KB boundary.
module dma_tlp_gen #(
  parameter int unsigned MAX_PAYLOAD_DW = 32,
  parameter int unsigned MAX_RDREQ_DW   = 128
) (
  input logic          wb_clk,
  input logic          rstn,
  dma_tlp_gen_if.slave bus
);

  typedef enum logic [2:0] {StIdle, StCalc, StHdr0, StHdr1, StData, StDone} state_e;

  state_e      state_q;
  logic        write_q;
  logic [29:0] addr_q;
  logic [15:0] rem_q;
  logic [7:0]  tag_q;
  logic [10:0] len_q;
  logic [9:0]  dcnt_q;
  logic [31:0] hold_q;

  logic [10:0] max_dw;
  logic [10:0] bound_4k;
  logic [10:0] calc_len;
  logic [15:0] rem_next;
  logic [15:0] req_len_eff;
  logic [31:0] dw0;
  logic [31:0] dw1;
  logic        tlp_last;

  always_comb begin
    max_dw   = write_q ? 11'(MAX_PAYLOAD_DW) : 11'(MAX_RDREQ_DW);
    // addr_q holds addr[31:2], so DWs left in the current 4KB page is 1024 - addr[11:2]
    bound_4k = 11'd1024 - {1'b0, addr_q[9:0]};
    calc_len = max_dw;
    if (bound_4k < calc_len) calc_len = bound_4k;
    if (rem_q < {5'd0, calc_len}) calc_len = rem_q[10:0];
    rem_next    = rem_q - {5'd0, len_q};
    req_len_eff = bus.req_write ? {bus.req_len_dw[15:1], 1'b0} : bus.req_len_dw;
    dw0 = {(write_q ? 8'h40 : 8'h00), 14'd0, len_q[9:0]};
    dw1 = {bus.requester_id, (write_q ? 8'h00 : tag_q), ((len_q == 11'd1) ? 4'h0 : 4'hF), 4'hF};
    tlp_last = ((state_q == StHdr1) && !write_q) || ((state_q == StData) && (dcnt_q == 10'd1));
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.pl_rd     = !bus.pl_empty &&
                         (((state_q == StHdr1) && write_q) ||
                          ((state_q == StData) && (dcnt_q != 10'd1)));

  always_ff @(posedge wb_clk or negedge rstn) begin
    if (!rstn) begin
      state_q        <= StIdle;
      write_q        <= 1'b0;
      addr_q         <= '0;
      rem_q          <= '0;
      tag_q          <= '0;
      len_q          <= '0;
      dcnt_q         <= '0;
      hold_q         <= '0;
      bus.tx_dv      <= 1'b0;
      bus.tx_st_in   <= 1'b0;
      bus.tx_end_in  <= 1'b0;
      bus.tx_dwen_in <= 1'b0;
      bus.tx_data_in <= '0;
      bus.req_done   <= 1'b0;
    end else begin
      bus.tx_dv      <= 1'b0;
      bus.tx_st_in   <= 1'b0;
      bus.tx_end_in  <= 1'b0;
      bus.tx_dwen_in <= 1'b0;
      bus.req_done   <= 1'b0;

      unique case (state_q)
        StIdle: begin
          if (bus.req_valid) begin
            write_q <= bus.req_write;
            addr_q  <= bus.req_addr[31:2];
            tag_q   <= bus.req_tag;
            rem_q   <= req_len_eff;
            if (req_len_eff == 16'd0) begin
              state_q      <= StDone;
              bus.req_done <= 1'b1;
            end else begin
              state_q <= StCalc;
            end
          end
        end
        StCalc: begin
          len_q   <= calc_len;
          state_q <= StHdr0;
        end
        StHdr0: begin
          if (!bus.fifo_full) begin
            bus.tx_dv      <= 1'b1;
            bus.tx_st_in   <= 1'b1;
            bus.tx_data_in <= {dw0, dw1};
            state_q        <= StHdr1;
          end
        end
        StHdr1: begin
          if (!write_q) begin
            bus.tx_dv      <= 1'b1;
            bus.tx_end_in  <= 1'b1;
            bus.tx_dwen_in <= 1'b1;
            bus.tx_data_in <= {addr_q, 2'b00, 32'h0};
          end else if (!bus.pl_empty) begin
            bus.tx_dv      <= 1'b1;
            bus.tx_data_in <= {addr_q, 2'b00, bus.pl_data[63:32]};
            hold_q         <= bus.pl_data[31:0];
            dcnt_q         <= len_q[10:1];
            state_q        <= StData;
          end
        end
        StData: begin
          if (dcnt_q == 10'd1) begin
            bus.tx_dv      <= 1'b1;
            bus.tx_end_in  <= 1'b1;
            bus.tx_dwen_in <= 1'b1;
            bus.tx_data_in <= {hold_q, 32'h0};
          end else if (!bus.pl_empty) begin
            bus.tx_dv      <= 1'b1;
            bus.tx_data_in <= {hold_q, bus.pl_data[63:32]};
            hold_q         <= bus.pl_data[31:0];
            dcnt_q         <= dcnt_q - 10'd1;
          end
        end
        StDone: state_q <= StIdle;
        default: state_q <= StIdle;
      endcase

      // Bookkeeping shared by the MRd header word and the final MWr data word
      if (tlp_last) begin
        addr_q <= addr_q + 30'(len_q);
        rem_q  <= rem_next;
        if (!write_q) tag_q <= tag_q + 8'd1;
        if (rem_next != 16'd0) begin
          state_q <= StCalc;
        end else begin
          state_q      <= StDone;
          bus.req_done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_dma_tlp_gen.sv
// Directed bench for dma_tlp_gen: a spec-level model fills a scoreboard of expected TX words,
// which a negedge monitor pops and compares as the DUT emits them.
module tb_dma_tlp_gen;
  localparam int MaxPayloadDw = 32;
  localparam int MaxRdreqDw   = 128;
  localparam logic [15:0] Rid = 16'hABCD;

  typedef struct packed {
    logic        st;
    logic        en;
    logic        dwen;
    logic [63:0] data;
  } word_t;

  logic wb_clk = 1'b0;
  logic rstn   = 1'b0;

  dma_tlp_gen_if bus ();

  dma_tlp_gen #(
    .MAX_PAYLOAD_DW(MaxPayloadDw),
    .MAX_RDREQ_DW  (MaxRdreqDw)
  ) dut (
    .wb_clk(wb_clk),
    .rstn  (rstn),
    .bus   (bus)
  );

  always #5 wb_clk = ~wb_clk;

  word_t       exp_q[$];
  logic [63:0] pl_q[$];
  logic [31:0] pay_dw[$];
  int total = 0, bad = 0;
  int tx_words = 0, st_words = 0, done_seen = 0, pops = 0, done_base = 0;
  bit pl_hold = 1'b0;

  task automatic check(string tag, logic [66:0] obs, logic [66:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // TX monitor and scoreboard
  always @(negedge wb_clk) begin
    word_t e;
    if (bus.req_done === 1'b1) done_seen++;
    if (bus.tx_dv === 1'b1) begin
      tx_words++;
      if (bus.tx_st_in) st_words++;
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $error("FAIL tx_unexpected observed=%h expected=none", bus.tx_data_in);
      end else begin
        e = exp_q.pop_front();
        check("tx_word", {bus.tx_st_in, bus.tx_end_in, bus.tx_dwen_in, bus.tx_data_in}, e);
      end
    end
  end

  // Show-ahead payload FIFO model
  always @(posedge wb_clk) begin
    if (bus.pl_rd === 1'b1) begin
      pops++;
      if (pl_q.size() > 0) void'(pl_q.pop_front());
    end
  end

  always @(negedge wb_clk) begin
    #1;
    bus.pl_empty = pl_hold || (pl_q.size() == 0);
    bus.pl_data  = (pl_q.size() > 0) ? pl_q[0] : 64'h0;
  end

  task automatic push_payload(int nwords, logic [63:0] base);
    logic [63:0] w;
    for (int i = 0; i < nwords; i++) begin
      w = base + 64'(i);
      pl_q.push_back(w);
      pay_dw.push_back(w[63:32]);
      pay_dw.push_back(w[31:0]);
    end
  endtask

  function automatic void model_req(bit wr, logic [31:0] a, int len, logic [7:0] tag_in);
    int rem, l, bnd;
    logic [31:0] addr, d0, d1;
    logic [7:0] tag;
    logic [9:0] lf;
    word_t w;
    rem  = wr ? (len & ~1) : len;
    addr = {a[31:2], 2'b00};
    tag  = tag_in;
    while (rem > 0) begin
      l   = wr ? MaxPayloadDw : MaxRdreqDw;
      bnd = (4096 - int'(addr[11:0])) / 4;
      if (bnd < l) l = bnd;
      if (rem < l) l = rem;
      lf = l[9:0];
      w.st = 1'b1; w.en = 1'b0; w.dwen = 1'b0;
      w.data = {(wr ? 8'h40 : 8'h00), 14'd0, lf, Rid, (wr ? 8'h00 : tag),
                ((l == 1) ? 4'h0 : 4'hF), 4'hF};
      exp_q.push_back(w);
      if (!wr) begin
        w.st = 1'b0; w.en = 1'b1; w.dwen = 1'b1; w.data = {addr, 32'h0};
        exp_q.push_back(w);
        tag = tag + 8'd1;
      end else begin
        w.st = 1'b0; w.en = 1'b0; w.dwen = 1'b0;
        d0 = pay_dw.pop_front();
        w.data = {addr, d0};
        exp_q.push_back(w);
        for (int k = 1; k < l; k += 2) begin
          d0 = pay_dw.pop_front();
          d1 = (k + 1 < l) ? pay_dw.pop_front() : 32'h0;
          w.en = (k + 1 >= l); w.dwen = (k + 1 >= l); w.data = {d0, d1};
          exp_q.push_back(w);
        end
      end
      addr = addr + 32'(l * 4);
      rem  = rem - l;
    end
  endfunction

  task automatic start_req(bit wr, logic [31:0] a, logic [15:0] len, logic [7:0] tag);
    int n;
    bit acc;
    n = 0;
    acc = 1'b0;
    done_base = done_seen;
    bus.req_write  = wr;
    bus.req_addr   = a;
    bus.req_len_dw = len;
    bus.req_tag    = tag;
    bus.req_valid  = 1'b1;
    while (!acc && n < 100) begin
      @(posedge wb_clk);
      acc = (bus.req_ready === 1'b1);
      n++;
    end
    #1 bus.req_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $error("FAIL accept_timeout observed=not_ready expected=ready");
    end
  endtask

  task automatic wait_done(string tag);
    int n;
    n = 0;
    while (done_seen == done_base && n < 400) begin
      @(negedge wb_clk);
      #2;
      n++;
    end
    check({tag, "_done"}, 67'(done_seen - done_base), 67'd1);
    check({tag, "_drained"}, 67'(exp_q.size()), 67'd0);
  endtask

  task automatic run_req(bit wr, logic [31:0] a, logic [15:0] len, logic [7:0] tag, string name);
    model_req(wr, a, int'(len), tag);
    start_req(wr, a, len, tag);
    wait_done(name);
  endtask

  initial begin
    int tw, sw, pp, n;
    bus.req_valid    = 1'b0;
    bus.req_write    = 1'b0;
    bus.req_addr     = '0;
    bus.req_len_dw   = '0;
    bus.req_tag      = '0;
    bus.requester_id = Rid;
    bus.fifo_full    = 1'b0;

    // Reset values
    repeat (3) @(negedge wb_clk);
    #2;
    check("rst_ctrl", {bus.tx_dv, bus.tx_st_in, bus.tx_end_in, bus.tx_dwen_in, bus.req_done,
                       bus.pl_rd}, 67'd0);
    check("rst_data", bus.tx_data_in, 67'd0);
    check("rst_ready", bus.req_ready, 67'd1);
    rstn = 1'b1;
    repeat (2) @(negedge wb_clk);
    #2;

    // T1: MWr 0x1000, 8 DWs, payload words 1..4
    tw = tx_words; sw = st_words; pp = pops;
    push_payload(4, 64'd1);
    run_req(1'b1, 32'h1000, 16'd8, 8'h00, "t1");
    check("t1_words", 67'(tx_words - tw), 67'd6);
    check("t1_pops", 67'(pops - pp), 67'd4);

    // T2: MRd 0x2000, 300 DWs, tag 5 -> 128/128/44
    tw = tx_words; sw = st_words;
    run_req(1'b0, 32'h2000, 16'd300, 8'd5, "t2");
    check("t2_tlps", 67'(st_words - sw), 67'd3);
    check("t2_words", 67'(tx_words - tw), 67'd6);

    // T3: MWr across 4KB boundary
    sw = st_words;
    push_payload(2, 64'hA5A5_0000_5A5A_0000);
    run_req(1'b1, 32'h0000_0FF8, 16'd4, 8'h00, "t3");
    check("t3_tlps", 67'(st_words - sw), 67'd2);

    // T4: single-DW read and zero-length request
    run_req(1'b0, 32'h0000_4004, 16'd1, 8'h20, "t4a");
    tw = tx_words;
    run_req(1'b1, 32'h0000_4100, 16'd0, 8'h00, "t4b");
    check("t4b_words", 67'(tx_words - tw), 67'd0);

    // T5a: fifo_full holds off the header
    bus.fifo_full = 1'b1;
    model_req(1'b0, 32'h0001_0000, 4, 8'h09);
    start_req(1'b0, 32'h0001_0000, 16'd4, 8'h09);
    for (int i = 0; i < 10; i++) begin
      @(negedge wb_clk);
      #2;
      check("t5_hold", bus.tx_dv, 67'd0);
    end
    bus.fifo_full = 1'b0;
    wait_done("t5a");

    // T5b: payload FIFO goes empty repeatedly mid-DATA
    push_payload(8, 64'h1234_5678_0000_0100);
    model_req(1'b1, 32'h0000_3000, 16, 8'h00);
    start_req(1'b1, 32'h0000_3000, 16'd16, 8'h00);
    for (int i = 0; i < 60 && done_seen == done_base; i++) begin
      @(negedge wb_clk);
      pl_hold = (i % 3) != 2;
    end
    pl_hold = 1'b0;
    wait_done("t5b");

    // T6: reset mid-DATA, then a clean request
    tw = tx_words;
    push_payload(8, 64'hDEAD_0000_BEEF_0000);
    model_req(1'b1, 32'h0000_5000, 16, 8'h00);
    start_req(1'b1, 32'h0000_5000, 16'd16, 8'h00);
    n = 0;
    while (tx_words < tw + 3 && n < 100) begin
      @(negedge wb_clk);
      #2;
      n++;
    end
    check("t6_reach_data", 67'(tx_words >= tw + 3), 67'd1);
    rstn = 1'b0;
    #1;
    check("t6_rst_ctrl", {bus.tx_dv, bus.tx_st_in, bus.tx_end_in, bus.tx_dwen_in, bus.req_done,
                          bus.pl_rd}, 67'd0);
    check("t6_rst_data", bus.tx_data_in, 67'd0);
    exp_q.delete();
    pl_q.delete();
    pay_dw.delete();
    repeat (2) @(negedge wb_clk);
    #2;
    rstn = 1'b1;
    @(negedge wb_clk);
    #2;
    push_payload(1, 64'h0BAD_F00D_CAFE_0001);
    run_req(1'b1, 32'h0000_6000, 16'd2, 8'h00, "t6");

    repeat (3) @(negedge wb_clk);
    #2;
    check("end_scoreboard", 67'(exp_q.size()), 67'd0);
    check("end_payload", 67'(pl_q.size()), 67'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
